// File: rtl/bist_ora.sv
`default_nettype none
// ============================================================================
// Module  : bist_ora
// Brief   : BIST output response analyzer: MISR compaction plus golden compare.
// Revision: 1.0  initial release
// ============================================================================
module bist_ora #(
    parameter int                 WIDTH    = 4,
    parameter int                 PATTERNS = 15,
    parameter logic [WIDTH-1:0]   POLY     = 4'b0011,
    parameter logic [WIDTH-1:0]   SEED     = 4'b0000,
    parameter logic [WIDTH-1:0]   GOLDEN   = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int             CW   = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0]  LAST = CW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMPRESS = 2'd1,
        S_COMPARE  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] misr_nxt;

    // Stage 0 always takes the feedback; POLY[0] is deliberately ignored.
    always_comb begin
        misr_nxt    = '0;
        misr_nxt[0] = sig_q[WIDTH-1] ^ R[0];
        for (int i = 1; i < WIDTH; i++) begin
            misr_nxt[i] = sig_q[i-1] ^ (POLY[i] & sig_q[WIDTH-1]) ^ R[i];
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_COMPRESS;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_COMPRESS: begin
                if (en) begin
                    sig_d = misr_nxt;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_COMPARE;
                    end
                end
            end
            S_COMPARE: begin
                pass_d  = (sig_q == GOLDEN);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // A new run requires en to drop first, so a held-high en cannot retrigger.
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign sig  = sig_q;
    assign busy = (state_q == S_COMPRESS) || (state_q == S_COMPARE);
    assign done = done_q;
    assign pass = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_ora.sv
`default_nettype none
// ============================================================================
// Module  : tb_bist_ora
// Brief   : Self-checking bench for bist_ora: reference model plus directed runs.
// Revision: 1.0  initial release
// ============================================================================
module tb_bist_ora;

    localparam logic [3:0] C_POLY = 4'b0011;
    localparam logic [3:0] C_SEED = 4'b0000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a  = 1'b0;
    logic       en_b  = 1'b0;
    logic [3:0] R_a   = 4'h0;
    logic [3:0] R_b   = 4'h0;
    logic       chk_on = 1'b0;

    logic [3:0] sig_a, sig_b, sig_c, sig_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;
    logic       pass_a, pass_b, pass_c, pass_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u_b/u_c/u_d share stimulus and differ only in run length and golden value.
    bist_ora #(.WIDTH(4), .PATTERNS(15), .POLY(C_POLY), .SEED(C_SEED), .GOLDEN(4'b0000)) u_a (
        .clk(clk), .rst(rst_n), .en(en_a), .R(R_a),
        .sig(sig_a), .busy(busy_a), .done(done_a), .pass(pass_a));
    bist_ora #(.WIDTH(4), .PATTERNS(5), .POLY(C_POLY), .SEED(C_SEED), .GOLDEN(4'b0011)) u_b (
        .clk(clk), .rst(rst_n), .en(en_b), .R(R_b),
        .sig(sig_b), .busy(busy_b), .done(done_b), .pass(pass_b));
    bist_ora #(.WIDTH(4), .PATTERNS(5), .POLY(C_POLY), .SEED(C_SEED), .GOLDEN(4'b1000)) u_c (
        .clk(clk), .rst(rst_n), .en(en_b), .R(R_b),
        .sig(sig_c), .busy(busy_c), .done(done_c), .pass(pass_c));
    bist_ora #(.WIDTH(4), .PATTERNS(1), .POLY(C_POLY), .SEED(C_SEED), .GOLDEN(4'b0001)) u_d (
        .clk(clk), .rst(rst_n), .en(en_b), .R(R_b),
        .sig(sig_d), .busy(busy_d), .done(done_d), .pass(pass_d));

    typedef struct packed {
        logic [3:0] sig;
        logic [7:0] taken;
        logic       collecting;
        logic       judging;
        logic       finished;
        logic       done;
        logic       pass;
    } mdl_t;

    mdl_t m_a, m_b, m_c, m_d;

    // Signature as a polynomial: multiply by x modulo the feedback polynomial, add R.
    function automatic logic [3:0] misr(input logic [3:0] s, input logic [3:0] r);
        logic [3:0] t;
        t = {s[2:0], 1'b0};
        if (s[3]) t = t ^ (C_POLY | 4'b0001);
        return t ^ r;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m     = '0;
        m.sig = C_SEED;
        return m;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic en, input logic [3:0] r,
                                  input int npat, input logic [3:0] gold);
        mdl_t n;
        n = m;
        if (m.judging) begin
            n.judging  = 1'b0;
            n.done     = 1'b1;
            n.pass     = (m.sig == gold);
            n.finished = 1'b1;
        end else if (m.collecting) begin
            if (en) begin
                n.sig   = misr(m.sig, r);
                n.taken = m.taken + 8'd1;
                if (int'(n.taken) == npat) begin
                    n.collecting = 1'b0;
                    n.judging    = 1'b1;
                end
            end
        end else if (m.finished) begin
            if (!en) n.finished = 1'b0;
        end else if (en) begin
            n.collecting = 1'b1;
            n.taken      = 8'd0;
            n.sig        = C_SEED;
            n.done       = 1'b0;
            n.pass       = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = mreset(); m_b = mreset(); m_c = mreset(); m_d = mreset();
        end else begin
            m_a = step(m_a, en_a, R_a, 15, 4'b0000);
            m_b = step(m_b, en_b, R_b, 5,  4'b0011);
            m_c = step(m_c, en_b, R_b, 5,  4'b1000);
            m_d = step(m_d, en_b, R_b, 1,  4'b0001);
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_unit(input string nm, input logic [3:0] s, input logic b,
                            input logic d, input logic p, input mdl_t m);
        mdl_t e;
        e = rst_n ? m : mreset();
        chk({nm, ".sig"},  s,          e.sig);
        chk({nm, ".busy"}, {3'b0, b},  {3'b0, e.collecting | e.judging});
        chk({nm, ".done"}, {3'b0, d},  {3'b0, e.done});
        chk({nm, ".pass"}, {3'b0, p},  {3'b0, e.pass});
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_unit("a", sig_a, busy_a, done_a, pass_a, m_a);
            cmp_unit("b", sig_b, busy_b, done_b, pass_b, m_b);
            cmp_unit("c", sig_c, busy_c, done_c, pass_c, m_c);
            cmp_unit("d", sig_d, busy_d, done_d, pass_d, m_d);
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(2);
        chk_on = 1'b1;
        chk("rst.sig_a",  sig_a, 4'h0);
        chk("rst.busy_a", {3'b0, busy_a}, 4'h0);
        chk("rst.done_b", {3'b0, done_b}, 4'h0);
        rst_n = 1'b1;
        tick(1);

        // All-zero run, 15 patterns: done after the 17th edge counting the start edge.
        en_a = 1'b1;
        R_a  = 4'h0;
        tick(16);
        chk("zero.done16", {3'b0, done_a}, 4'h0);
        chk("zero.busy16", {3'b0, busy_a}, 4'h1);
        tick(1);
        chk("zero.done17", {3'b0, done_a}, 4'h1);
        chk("zero.pass",   {3'b0, pass_a}, 4'h1);
        chk("zero.sig",    sig_a, 4'h0);
        en_a = 1'b0;
        tick(2);

        // Shift/feedback: R=0001 then 0000 x4.
        en_b = 1'b1;
        R_b  = 4'b0001;
        tick(1);
        chk("shf.busy_b", {3'b0, busy_b}, 4'h1);
        tick(1);
        chk("shf.s1", sig_b, 4'b0001);
        R_b = 4'b0000;
        tick(1); chk("shf.s2", sig_b, 4'b0010);
        tick(1); chk("shf.s3", sig_b, 4'b0100);
        chk("p1.done_d", {3'b0, done_d}, 4'h1);
        chk("p1.pass_d", {3'b0, pass_d}, 4'h1);
        tick(1); chk("shf.s4", sig_b, 4'b1000);
        tick(1); chk("shf.s5", sig_b, 4'b0011);
        chk("shf.done_pre", {3'b0, done_b}, 4'h0);
        tick(1);
        chk("shf.done_b", {3'b0, done_b}, 4'h1);
        chk("shf.pass_b", {3'b0, pass_b}, 4'h1);
        chk("mis.done_c", {3'b0, done_c}, 4'h1);
        chk("mis.pass_c", {3'b0, pass_c}, 4'h0);

        // Held-high en after completion must not restart.
        tick(4);
        chk("hold.busy_b", {3'b0, busy_b}, 4'h0);
        chk("hold.done_b", {3'b0, done_b}, 4'h1);
        en_b = 1'b0;
        tick(1);
        chk("idle.done_b", {3'b0, done_b}, 4'h1);
        en_b = 1'b1;
        R_b  = 4'b0001;
        tick(1);
        chk("rst.done_b2", {3'b0, done_b}, 4'h0);
        chk("rst.sig_b2",  sig_b, C_SEED);

        // Second run with a 3-cycle pause after the 2nd sample; R garbage while paused.
        tick(1);
        R_b = 4'b0000;
        tick(1);
        chk("pau.s2", sig_b, 4'b0010);
        en_b = 1'b0;
        R_b  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("pau.hold", sig_b, 4'b0010);
        end
        en_b = 1'b1;
        R_b  = 4'b0000;
        tick(3);
        chk("pau.final", sig_b, 4'b0011);
        en_b = 1'b0;
        R_b  = 4'b1111;
        tick(1);
        chk("pau.done", {3'b0, done_b}, 4'h1);
        chk("pau.pass", {3'b0, pass_b}, 4'h1);
        tick(1);

        // Asynchronous reset mid-compress, observed before any further edge.
        en_a = 1'b1;
        R_a  = 4'b0101;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.sig_a",  sig_a, C_SEED);
        chk("arst.busy_a", {3'b0, busy_a}, 4'h0);
        chk("arst.done_b", {3'b0, done_b}, 4'h0);
        chk("arst.pass_b", {3'b0, pass_b}, 4'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("arst.rerun", {3'b0, busy_a}, 4'h1);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
